fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 76 +++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// request/ready handshake and holds one instruction for decode.
module fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        halt,
   output logic [15:0] instruction,
   output logic [15:0] pc_inc,
   output logic        inst_valid,
   output logic        halted,
   output logic        err
);

   typedef enum logic {RUN, HALTED} state_t;

   state_t      state;
   logic [15:0] pc;
   logic [15:0] pc_next;
   logic        fetch_done;
   logic        consume;

   // rst is folded in so the request drops the instant reset asserts
   assign imem_req   = rst && (state == RUN) && (!inst_valid || !stall);
   assign imem_addr  = pc;
   assign pc_next    = pc + 16'd2;
   assign fetch_done = imem_req && imem_ready;
   assign consume    = inst_valid && !stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RUN;
         pc          <= RESET_PC;
         instruction <= NOP_INSTR;
         pc_inc      <= '0;
         inst_valid  <= 1'b0;
         halted      <= 1'b0;
         err         <= 1'b0;
      end else if (state == RUN) begin
         if (halt && consume) begin
            state       <= HALTED;
            halted      <= 1'b1;
            inst_valid  <= 1'b0;
            instruction <= NOP_INSTR;
         end else if (redirect) begin
            // any fetch completing this cycle belongs to the old path
            pc          <= redirect_pc;
            inst_valid  <= 1'b0;
            instruction <= NOP_INSTR;
            if (redirect_pc[0]) begin
               err    <= 1'b1;
               halted <= 1'b1;
               state  <= HALTED;
            end
         end else if (fetch_done) begin
            instruction <= imem_data;
            pc_inc      <= pc_next;
            inst_valid  <= 1'b1;
            pc          <= pc_next;
         end else if (consume) begin
            inst_valid  <= 1'b0;
            instruction <= NOP_INSTR;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all
// compared against a rule-level model of the fetch stage.
module tb_fetch_unit;

   localparam logic [15:0] NOP = 16'h0800;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [15:0] imem_data;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0;
   logic        halt = 1'b0;
   logic [15:0] instruction;
   logic [15:0] pc_inc;
   logic        inst_valid;
   logic        halted;
   logic        err;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   logic [15:0] m_pc, m_instr, m_pcinc;
   logic        m_valid, m_halted, m_err;

   always #5 clk = ~clk;

   // memory returns 0x1000 + address with no wait unless imem_ready is low
   assign imem_data = 16'h1000 + imem_addr;

   fetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_data(imem_data),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .instruction(instruction), .pc_inc(pc_inc), .inst_valid(inst_valid),
      .halted(halted), .err(err)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic model_req(input logic s_stall);
      return rst && !m_halted && (!m_valid || !s_stall);
   endfunction

   task automatic model_reset();
      m_pc = 16'h0000; m_instr = NOP; m_pcinc = 16'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0;
   endtask

   // one clock of the fetch rules, highest-priority event wins
   task automatic model_clock(input logic s_ready, input logic s_stall, input logic s_redir,
                              input logic [15:0] s_rpc, input logic s_halt);
      logic takes_fetch, consumed;
      takes_fetch = model_req(s_stall) && s_ready;
      consumed    = m_valid && !s_stall;
      if (m_halted) return;
      if (s_halt && consumed) begin
         m_halted = 1'b1; m_valid = 1'b0; m_instr = NOP;
      end else if (s_redir) begin
         m_pc = s_rpc; m_valid = 1'b0; m_instr = NOP;
         if (s_rpc[0]) begin m_err = 1'b1; m_halted = 1'b1; end
      end else if (takes_fetch) begin
         m_instr = 16'h1000 + m_pc;
         m_pc    = m_pc + 16'd2;
         m_pcinc = m_pc;
         m_valid = 1'b1;
      end else if (consumed) begin
         m_valid = 1'b0; m_instr = NOP;
      end
   endtask

   task automatic chk_outputs();
      chk("instruction", instruction, m_instr);
      chk("pc_inc", pc_inc, m_pcinc);
      chk("inst_valid", {15'b0, inst_valid}, {15'b0, m_valid});
      chk("halted", {15'b0, halted}, {15'b0, m_halted});
      chk("err", {15'b0, err}, {15'b0, m_err});
   endtask

   // starts and ends just after a falling edge
   task automatic step(input logic s_ready, input logic s_stall, input logic s_redir,
                       input logic [15:0] s_rpc, input logic s_halt);
      imem_ready = s_ready; stall = s_stall; redirect = s_redir;
      redirect_pc = s_rpc; halt = s_halt;
      #1;
      chk("imem_req", {15'b0, imem_req}, {15'b0, model_req(s_stall)});
      chk("imem_addr", imem_addr, m_pc);
      @(posedge clk);
      model_clock(s_ready, s_stall, s_redir, s_rpc, s_halt);
      #1;
      chk_outputs();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      #1;
      chk("rst_imem_req", {15'b0, imem_req}, 16'h0);
      chk("rst_imem_addr", imem_addr, 16'h0000);
      chk_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();

      // zero-wait fetch after reset release
      step(1, 0, 0, 16'h0, 0);
      chk("first_instr", instruction, 16'h1000);
      step(1, 0, 0, 16'h0, 0);
      chk("second_pc_inc", pc_inc, 16'h0004);

      // stall for two cycles while 1002 is presented
      step(1, 1, 0, 16'h0, 0);
      step(1, 1, 0, 16'h0, 0);
      chk("stall_hold", instruction, 16'h1002);

      // memory waits three cycles on address 4
      step(0, 0, 0, 16'h0, 0);
      step(0, 0, 0, 16'h0, 0);
      step(0, 0, 0, 16'h0, 0);
      chk("wait_addr", imem_addr, 16'h0004);
      step(1, 0, 0, 16'h0, 0);
      chk("after_wait", instruction, 16'h1004);
      chk("after_wait_pc_inc", pc_inc, 16'h0006);

      // redirect collides with completing fetch of 1006
      step(1, 0, 1, 16'h0040, 0);
      step(1, 0, 0, 16'h0, 0);
      chk("redirect_target", instruction, 16'h1040);
      chk("redirect_pc_inc", pc_inc, 16'h0042);

      // misaligned redirect
      step(1, 0, 1, 16'h0041, 0);
      step(1, 0, 0, 16'h0, 0);
      chk("misaligned_err", {15'b0, err}, 16'h0001);

      // halt, then a redirect that must be ignored
      do_reset();
      step(1, 0, 0, 16'h0, 0);
      step(1, 0, 0, 16'h0, 1);
      chk("halt_instr", instruction, NOP);
      step(1, 0, 1, 16'h0100, 0);
      step(1, 0, 0, 16'h0, 0);
      chk("halt_addr_frozen", imem_addr, 16'h0002);

      // reset restores fetch; then PC wrap at FFFE
      do_reset();
      step(1, 0, 1, 16'hFFFE, 0);
      step(1, 0, 0, 16'h0, 0);
      chk("wrap_pc_inc", pc_inc, 16'h0000);
      step(1, 0, 0, 16'h0, 0);
      chk("wrap_next", instruction, 16'h1000);
      chk("wrap_no_err", {15'b0, err}, 16'h0000);

      // asynchronous reset in the middle of a waiting request
      step(0, 0, 1, 16'h0200, 0);
      imem_ready = 1'b0;
      #2;
      do_reset();

      // random traffic with periodic resets
      for (int i = 0; i < 600; i++) begin
         logic r_rdy, r_stl, r_rdr, r_hlt;
         logic [15:0] r_pc;
         if (i % 75 == 74) do_reset();
         r_rdy = ($urandom_range(0, 3) != 0);
         r_stl = ($urandom_range(0, 9) < 3);
         r_rdr = ($urandom_range(0, 19) == 0);
         r_hlt = ($urandom_range(0, 39) == 0);
         r_pc  = 16'($urandom) & 16'hFFFE;
         if ($urandom_range(0, 15) == 0) r_pc[0] = 1'b1;
         step(r_rdy, r_stl, r_rdr, r_pc, r_hlt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
